mem_access: RTL
===============

Name: mem_access

Overview:
- MEM-stage data-memory access unit of the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Takes the effective address, store data and load/store flags from EX/MEM, drives the data-memory bus with a req/ack handshake, and stalls the pipeline until the access completes.
- Returns load data aligned and sign/zero-extended on mem_dout.

Parameters:
TIMEOUT_CYCLES, 255, REQ cycles without mem_ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
inst  in  32  instruction in MEM stage; inst[31:26] selects access size/sign
addr  in  32  effective address (ALU result)
store_val  in  32  rt value to store
load  in  1  instruction is a load
store  in  1  instruction is a store
mem_req  out  1  bus request, registered
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  30  word address = addr[31:2]
mem_be  out  4  byte enables, little-endian
mem_wdata  out  32  store data replicated to the addressed lanes
mem_ack  in  1  memory completed the request this cycle
mem_rdata  in  32  read word, valid with mem_ack
mem_dout  out  32  aligned/extended load result to MEM/WB
stall  out  1  hold IF..EX/MEM this cycle
addr_err  out  1  misaligned access (combinational)
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Any other opcode with load|store asserted is treated as word size.
- Byte lane n holds bits 8n+7:8n and is selected by addr[1:0]=n.
- Lane mapping:
  - Byte access: be = 1<<addr[1:0], wdata = {4{store_val[7:0]}}.
  - Half access: be = 4'b0011 << addr[1:0], wdata = {2{store_val[15:0]}}.
  - Word access: be = 4'b1111, wdata = store_val.
- Misalignment:
  - Half with addr[0]=1, or word with addr[1:0]!=0, sets addr_err=1 while presented.
  - No request is issued, stall=0 and mem_dout=0, so the pipeline advances; trap handling is upstream's job.
- FSM states: IDLE, REQ, DONE. Transitions:
  - IDLE: (load|store) && !addr_err -> REQ. In the transition cycle stall=1 and mem_req, mem_we, mem_addr, mem_be, mem_wdata are registered.
  - REQ: mem_req=1 and stall=1. The registered bus outputs are held stable until mem_ack. On mem_ack -> DONE; for loads, the extracted and extended data is latched into mem_dout.
  - DONE: mem_req=0, stall=0, mem_dout holds the result; the pipeline advances at this edge. Always -> IDLE.
- Best-case latency: 3 cycles (IDLE, REQ with same-cycle ack, DONE), 2 of them stalled. Each extra wait cycle adds one.
- Back-to-back accesses: the next access is detected in IDLE the cycle after DONE.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend. Stores leave mem_dout=0.
- mem_ack outside REQ is ignored.
- Reset values (any state, including mid-REQ): state IDLE; mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_dout, bus_err all 0. The abandoned transaction is dropped and memory must tolerate this.
- stall is combinational from state and inputs; it is 0 when neither load nor store is asserted.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8+ bit counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: go to DONE, drop mem_req, set mem_dout=0, pulse bus_err for the DONE cycle.
  - An ack in the same cycle as expiry wins; there is no bus_err in that case.
- Undefined: no counter; bus_err tied 0; REQ waits indefinitely.

Test Plan:
- LW addr=0x100, mem_ack same cycle as mem_req, rdata=0xDEADBEEF -> mem_addr=0x40, be=1111, stall high 2 cycles, mem_dout=0xDEADBEEF in DONE.
- LB addr=0x103, rdata=0x80112233 -> be=1000, mem_dout=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x102 -> mem_dout=0xFFFF8011.
- SH addr=0x202, store_val=0x1234ABCD, ack after 3 wait cycles -> mem_we=1, be=1100, wdata=0xABCDABCD, stall high 5 cycles, bus outputs stable throughout REQ.
- LW addr=0x101 -> addr_err=1, stall=0, mem_req never asserted; SW addr=0x106 -> same.
- rst asserted during REQ of SW -> mem_req/mem_we drop immediately, state IDLE; the next LW completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then bus_err=1 for one cycle with stall=0 and mem_dout=0.

Source files
------------

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Brief    : Data-memory bus (req/ack handshake) between MEM stage and memory.
// Revision : 1.0
// ============================================================================
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Brief    : MIPS MEM-stage load/store unit; stalls until the bus acks.
//            Optional REQ timeout abort enabled by macro MEM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] inst,
  input  wire logic [31:0] addr,
  input  wire logic [31:0] store_val,
  input  wire logic        load,
  input  wire logic        store,
  mem_access_if.master     bus,
  output logic      [31:0] mem_dout,
  output logic             stall,
  output logic             addr_err,
  output logic             bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] c_sz_byte = 2'd0;
  localparam logic [1:0] c_sz_half = 2'd1;
  localparam logic [1:0] c_sz_word = 2'd2;

  state_t      r_state;
  logic        r_req, r_we, r_is_load, r_uns, r_bus_err;
  logic [29:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata, r_dout;
  logic [1:0]  r_lane, r_size;

  logic [5:0]  w_op;
  logic [1:0]  w_size;
  logic        w_uns, w_access, w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_ext;

  assign w_op     = inst[31:26];
  assign w_access = load | store;

  always_comb begin
    w_size = c_sz_word;
    w_uns  = 1'b0;
    case (w_op)
      6'h20, 6'h28: w_size = c_sz_byte;
      6'h24: begin w_size = c_sz_byte; w_uns = 1'b1; end
      6'h21, 6'h29: w_size = c_sz_half;
      6'h25: begin w_size = c_sz_half; w_uns = 1'b1; end
      default: w_size = c_sz_word;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_val;
    case (w_size)
      c_sz_byte: begin w_be = 4'b0001 << addr[1:0]; w_wdata = {4{store_val[7:0]}}; end
      c_sz_half: begin w_be = 4'b0011 << addr[1:0]; w_wdata = {2{store_val[15:0]}}; end
      default:   begin w_be = 4'b1111;              w_wdata = store_val;            end
    endcase
  end

  assign addr_err = w_access &&
                    (((w_size == c_sz_half) && addr[0]) ||
                     ((w_size == c_sz_word) && (addr[1:0] != 2'b00)));
  assign w_start  = w_access && !addr_err;
  assign stall    = w_access && (((r_state == IDLE) && !addr_err) || (r_state == REQ));

  // Extract the addressed lane from the returned word, then extend.
  assign w_shift = bus.mem_rdata >> {r_lane, 3'b000};
  always_comb begin
    w_ext = w_shift;
    case (r_size)
      c_sz_byte: w_ext = {{24{~r_uns & w_shift[7]}},  w_shift[7:0]};
      c_sz_half: w_ext = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
      default:   w_ext = w_shift;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_unused;
  assign w_unused = &{1'b0, inst[25:0]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, inst[25:0], (TIMEOUT_CYCLES > 0)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_dout    <= '0;
      r_bus_err <= 1'b0;
      r_lane    <= '0;
      r_size    <= c_sz_word;
      r_uns     <= 1'b0;
      r_is_load <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= REQ;
            r_req     <= 1'b1;
            r_we      <= store;
            r_addr    <= addr[31:2];
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_lane    <= addr[1:0];
            r_size    <= w_size;
            r_uns     <= w_uns;
            r_is_load <= ~store;
            r_dout    <= '0;
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        REQ: begin
          // An ack takes priority over an expiring timeout.
          if (bus.mem_ack) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            if (r_is_load) r_dout <= w_ext;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= DONE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_dout    <= '0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
`endif
        end
        DONE: begin
          r_state   <= IDLE;
          r_bus_err <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;
  assign mem_dout      = addr_err ? 32'h0 : r_dout;
  assign bus_err       = r_bus_err;

endmodule
`default_nettype wire
